// File: rtl/impulse_reader.sv
`default_nettype none
// ============================================================================
// Module  : impulse_reader
// Brief   : On each trigger, reads the stored impulse response from BRAM
//           port B and streams it out as valid/ready taps. Define
//           IMPULSE_READER_REVERSE_EN to read addresses in descending order.
// Revision: 1.0
// ============================================================================
module impulse_reader #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                  audio_clk,
  input  logic                  rst_in,
  input  logic                  impulse_recorded,
  input  logic                  audio_trigger,
  input  logic [ADDR_WIDTH-1:0] impulse_length,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] tap_data,
  output logic [ADDR_WIDTH-1:0] tap_index,
  output logic                  tap_valid,
  input  logic                  tap_ready,
  output logic                  tap_last,
  output logic                  sweep_done,
  output logic                  overrun
);

  localparam int c_DEPTH = READ_LATENCY + 2;
  localparam int c_PW    = (c_DEPTH > 1) ? $clog2(c_DEPTH) : 1;
  localparam int c_CW    = $clog2(c_DEPTH + 1) + 1;
  localparam logic [c_CW-1:0]       c_DEPTH_CNT = c_CW'(c_DEPTH);
  localparam logic [c_PW-1:0]       c_LAST_PTR  = c_PW'(c_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ONE       = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_len;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic                  r_sweep_done;

  // Tag pipeline; stage 0 is the registered BRAM request itself.
  logic                  r_pipe_v    [0:READ_LATENCY];
  logic [ADDR_WIDTH-1:0] r_pipe_idx  [0:READ_LATENCY];
  logic                  r_pipe_last [0:READ_LATENCY];

  logic [DATA_WIDTH-1:0] r_mem_data [0:c_DEPTH-1];
  logic [ADDR_WIDTH-1:0] r_mem_idx  [0:c_DEPTH-1];
  logic                  r_mem_last [0:c_DEPTH-1];
  logic [c_PW-1:0]       r_wr_ptr;
  logic [c_PW-1:0]       r_rd_ptr;
  logic [c_CW-1:0]       r_count;

  logic                  w_hs;
  logic                  w_push;
  logic                  w_start;
  logic                  w_issue;
  logic                  w_issue_last;
  logic [ADDR_WIDTH-1:0] w_len;
  logic [ADDR_WIDTH-1:0] w_cnt;
  logic [ADDR_WIDTH-1:0] w_issue_addr;
  logic [c_CW-1:0]       w_in_flight;
  logic [c_CW-1:0]       w_occupancy;

  always_comb begin
    w_in_flight = '0;
    for (int k = 0; k <= READ_LATENCY; k++) begin
      w_in_flight = w_in_flight + c_CW'(r_pipe_v[k]);
    end
  end

  assign tap_valid = (r_count != '0);
  assign tap_data  = tap_valid ? r_mem_data[r_rd_ptr] : '0;
  assign tap_index = tap_valid ? r_mem_idx[r_rd_ptr]  : '0;
  assign tap_last  = tap_valid ? r_mem_last[r_rd_ptr] : 1'b0;
  assign rd_en     = r_pipe_v[0];
  assign rd_addr   = r_pipe_idx[0];
  assign sweep_done = r_sweep_done;
  assign overrun   = audio_trigger && (r_state != IDLE);

  assign w_hs   = tap_valid && tap_ready;
  assign w_push = r_pipe_v[READ_LATENCY];

  // A head popped this cycle frees its slot, so full throughput survives.
  assign w_occupancy = w_in_flight + r_count - c_CW'(w_hs);

  assign w_start = (r_state == IDLE) && audio_trigger && impulse_recorded;
  assign w_len   = (r_state == IDLE) ? impulse_length : r_len;
  assign w_cnt   = (r_state == IDLE) ? '0 : r_cnt;
  assign w_issue = (w_start && (impulse_length != '0)) ||
                   ((r_state == SWEEP) && (w_occupancy < c_DEPTH_CNT));
  assign w_issue_last = (w_cnt == (w_len - c_ONE));

`ifdef IMPULSE_READER_REVERSE_EN
  assign w_issue_addr = w_len - c_ONE - w_cnt;
`else
  assign w_issue_addr = w_cnt;
`endif

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      r_sweep_done <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      for (int k = 0; k <= READ_LATENCY; k++) begin
        r_pipe_v[k]    <= 1'b0;
        r_pipe_idx[k]  <= '0;
        r_pipe_last[k] <= 1'b0;
      end
      for (int k = 0; k < c_DEPTH; k++) begin
        r_mem_data[k] <= '0;
        r_mem_idx[k]  <= '0;
        r_mem_last[k] <= 1'b0;
      end
    end else begin
      r_pipe_v[0] <= w_issue;
      if (w_issue) begin
        r_pipe_idx[0]  <= w_issue_addr;
        r_pipe_last[0] <= w_issue_last;
        r_cnt          <= w_cnt + c_ONE;
      end
      for (int k = 1; k <= READ_LATENCY; k++) begin
        r_pipe_v[k]    <= r_pipe_v[k-1];
        r_pipe_idx[k]  <= r_pipe_idx[k-1];
        r_pipe_last[k] <= r_pipe_last[k-1];
      end

      if (w_push) begin
        r_mem_data[r_wr_ptr] <= rd_data;
        r_mem_idx[r_wr_ptr]  <= r_pipe_idx[READ_LATENCY];
        r_mem_last[r_wr_ptr] <= r_pipe_last[READ_LATENCY];
        r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + c_PW'(1);
      end
      if (w_hs) begin
        r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + c_PW'(1);
      end
      r_count <= r_count + c_CW'(w_push) - c_CW'(w_hs);

      r_sweep_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_len <= impulse_length;
            if (impulse_length == '0) begin
              r_state <= DONE;
            end else if (w_issue_last) begin
              r_state <= DRAIN;
            end else begin
              r_state <= SWEEP;
            end
          end
        end
        SWEEP: begin
          if (w_issue && w_issue_last) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_hs && tap_last && (w_in_flight == '0)) begin
            r_state      <= DONE;
            r_sweep_done <= 1'b1;
          end
        end
        DONE: begin
          // An empty sweep enters DONE without the pulse; emit it here first.
          if (!r_sweep_done) begin
            r_sweep_done <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_impulse_reader.sv
`default_nettype none
// ============================================================================
// Module  : tb_impulse_reader
// Brief   : Scoreboard bench for impulse_reader with a BRAM read model.
// Revision: 1.0
// ============================================================================
module tb_impulse_reader;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int RL = 2;

  logic          audio_clk = 1'b0;
  logic          rst_in = 1'b1;
  logic          impulse_recorded = 1'b0;
  logic          audio_trigger = 1'b0;
  logic [AW-1:0] impulse_length = '0;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] tap_data;
  logic [AW-1:0] tap_index;
  logic          tap_valid;
  logic          tap_ready;
  logic          tap_last;
  logic          sweep_done;
  logic          overrun;

  impulse_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
    .audio_clk(audio_clk), .rst_in(rst_in), .impulse_recorded(impulse_recorded),
    .audio_trigger(audio_trigger), .impulse_length(impulse_length),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .tap_data(tap_data), .tap_index(tap_index), .tap_valid(tap_valid),
    .tap_ready(tap_ready), .tap_last(tap_last), .sweep_done(sweep_done),
    .overrun(overrun)
  );

  always #5 audio_clk = ~audio_clk;

  int cyc = 0;
  always @(posedge audio_clk) cyc <= cyc + 1;

  // BRAM port B model: mem[a] = 0x1000 + a, two-cycle read latency.
  logic [DW-1:0] bram_p1 = '0;
  logic [DW-1:0] bram_p2 = '0;
  always @(posedge audio_clk) begin
    bram_p1 <= rd_en ? (16'h1000 + rd_addr) : 16'hDEAD;
    bram_p2 <= bram_p1;
  end
  assign rd_data = bram_p2;

  typedef struct {
    logic [DW-1:0] data;
    logic [AW-1:0] idx;
    logic          last;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   ovr_q[$];

  int checks = 0;
  int errors = 0;
  bit quiet = 1'b0;
  bit toggle_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [AW-1:0] exp_idx(input int len, input int i);
`ifdef IMPULSE_READER_REVERSE_EN
    return AW'(len - 1 - i);
`else
    return AW'(i);
`endif
  endfunction

  // Ready driver: held high, or cycling 1,0,0,1 when toggle_en is set.
  int pat [4] = '{1, 0, 0, 1};
  initial begin
    int ph = 0;
    tap_ready = 1'b1;
    forever begin
      @(posedge audio_clk); #1;
      if (toggle_en) begin
        tap_ready = pat[ph][0];
        ph = (ph + 1) % 4;
      end else begin
        tap_ready = 1'b1;
        ph = 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  exp_t          e;
  int            d;
  int            issued = 0;
  int            consumed = 0;
  int            last_hs = -100;
  bit            stall_prev = 1'b0;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_idx;
  logic          prev_last;

  always @(negedge audio_clk) begin
    if (rst_in) begin
      exp_q.delete();
      done_q.delete();
      ovr_q.delete();
      issued = 0;
      consumed = 0;
      stall_prev = 1'b0;
    end else begin
      if (rd_en) begin
        issued++;
        chk("outstanding_le4", 32'(issued - consumed <= 4), 32'd1);
      end
      if (stall_prev) begin
        chk("stall_valid", 32'(tap_valid), 32'd1);
        chk("stall_data", 32'(tap_data), 32'(prev_data));
        chk("stall_index", 32'(tap_index), 32'(prev_idx));
        chk("stall_last", 32'(tap_last), 32'(prev_last));
      end
      stall_prev = tap_valid && !tap_ready;
      prev_data = tap_data;
      prev_idx = tap_index;
      prev_last = tap_last;

      if (tap_valid && tap_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_tap", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("tap_data", 32'(tap_data), 32'(e.data));
          chk("tap_index", 32'(tap_index), 32'(e.idx));
          chk("tap_last", 32'(tap_last), 32'(e.last));
          if (e.cyc >= 0) chk("tap_cycle", 32'(cyc), 32'(e.cyc));
          if (e.last) last_hs = cyc;
        end
        consumed++;
      end else if (exp_q.size() == 0) begin
        chk("idle_tap_valid", 32'(tap_valid), 32'd0);
      end

      if (sweep_done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_sweep_done", 32'd1, 32'd0);
        end else begin
          d = done_q.pop_front();
          if (d >= 0) chk("sweep_done_cycle", 32'(cyc), 32'(d));
          else        chk("sweep_done_after_last", 32'(cyc), 32'(last_hs + 1));
        end
      end

      if (overrun) begin
        if (ovr_q.size() == 0) begin
          chk("unexpected_overrun", 32'd1, 32'd0);
        end else begin
          d = ovr_q.pop_front();
          chk("overrun_cycle", 32'(cyc), 32'(d));
        end
      end

      if (quiet) begin
        chk("quiet_rd_en", 32'(rd_en), 32'd0);
        chk("quiet_sweep_done", 32'(sweep_done), 32'd0);
        chk("quiet_overrun", 32'(overrun), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge audio_clk); #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'd0);
    chk({tag, "_tap_data"}, 32'(tap_data), 32'd0);
    chk({tag, "_tap_index"}, 32'(tap_index), 32'd0);
    chk({tag, "_tap_valid"}, 32'(tap_valid), 32'd0);
    chk({tag, "_tap_last"}, 32'(tap_last), 32'd0);
    chk({tag, "_sweep_done"}, 32'(sweep_done), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
  endtask

  // One-cycle trigger at cycle t; expected taps and sweep_done are queued.
  task automatic fire(input int len, input bit rec, input bit timed, output int t);
    exp_t x;
    step();
    impulse_length = AW'(len);
    impulse_recorded = rec;
    audio_trigger = 1'b1;
    t = cyc;
    if (rec && len > 0) begin
      for (int i = 0; i < len; i++) begin
        x.idx  = exp_idx(len, i);
        x.data = 16'h1000 + x.idx;
        x.last = (i == len - 1);
        x.cyc  = timed ? t + RL + 2 + i : -1;
        exp_q.push_back(x);
      end
      done_q.push_back(timed ? t + RL + 2 + len : -1);
    end else if (rec) begin
      done_q.push_back(t + 2);
    end
    step();
    audio_trigger = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || ovr_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk({name, "_completed"}, 32'(n < 200), 32'd1);
    if (n >= 200) begin
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
    end
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    #1;
    check_all_zero("reset");
    repeat (3) step();
    rst_in = 1'b0;
    repeat (2) step();

    // Straight sweep of 8; impulse_length change mid-sweep must be ignored.
    fire(8, 1'b1, 1'b1, t);
    impulse_length = 16'd3;
    drain("sweep8");

    // Backpressure pattern 1,0,0,1.
    toggle_en = 1'b1;
    fire(8, 1'b1, 1'b0, t);
    drain("stall8");
    toggle_en = 1'b0;
    repeat (2) step();

    // Zero-length sweep.
    fire(0, 1'b1, 1'b1, t);
    drain("len0");

    // No recorded impulse: trigger ignored entirely.
    quiet = 1'b1;
    fire(8, 1'b0, 1'b1, t);
    repeat (12) step();
    quiet = 1'b0;

    // Overrun mid-sweep (with recorded dropped) and on the sweep_done cycle.
    fire(16, 1'b1, 1'b1, t);
    goto(t + 2);
    impulse_recorded = 1'b0;
    impulse_length = 16'd5;
    goto(t + 5);
    audio_trigger = 1'b1;
    ovr_q.push_back(t + 5);
    goto(t + 6);
    audio_trigger = 1'b0;
    impulse_recorded = 1'b1;
    goto(t + 20);
    audio_trigger = 1'b1;
    ovr_q.push_back(t + 20);
    goto(t + 21);
    audio_trigger = 1'b0;
    drain("overrun16");

    // Asynchronous reset while tap 3 is at the head.
    fire(8, 1'b1, 1'b1, t);
    goto(t + 7);
    #1;
    chk("pre_reset_valid", 32'(tap_valid), 32'd1);
    chk("pre_reset_index", 32'(tap_index), 32'(exp_idx(8, 3)));
    rst_in = 1'b1;
    #1;
    check_all_zero("async_reset");
    step();
    rst_in = 1'b0;
    repeat (2) step();
    fire(8, 1'b1, 1'b1, t);
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
